// File: rtl/io_write_arbiter.sv
// -----------------------------------------------------------------------------
// io_write_arbiter
// Arbitrates the shared IO write port between the layer loader, the file
// writer and the decompressor. Grants whole bursts, drives the select lines
// of the one-bit write-source mux array, and keeps one persistent address
// counter per source so a pre-empted source resumes where it stopped.
//
// Ports:
//   clk                       system clock, rising edge
//   reset                     asynchronous, active-high reset
//   req_layer/file/decomp     level request, held while the source has data
//   valid_layer/file/decomp   source presents a word this cycle
//   last_layer/file/decomp    qualifies valid; final word of the burst
//   clr_addr                  reload all three address counters to base
//   gnt_layer/file/decomp     one-hot grant (registered)
//   Write_Layer/Write_Files/File_Type  mux selects (registered)
//   mem_we                    write strobe (combinational)
//   mem_addr                  counter of the granted source, layer counter idle
//   burst_cnt                 words accepted in the current grant
// -----------------------------------------------------------------------------
module io_write_arbiter #(
    parameter int                ADDR_W      = 16,
    parameter int                BURST_MAX   = 64,
    parameter logic [ADDR_W-1:0] LAYER_BASE  = 16'h0000,
    parameter logic [ADDR_W-1:0] FILE_BASE   = 16'h4000,
    parameter logic [ADDR_W-1:0] DECOMP_BASE = 16'h8000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_layer,
    input  logic              req_file,
    input  logic              req_decomp,
    input  logic              valid_layer,
    input  logic              valid_file,
    input  logic              valid_decomp,
    input  logic              last_layer,
    input  logic              last_file,
    input  logic              last_decomp,
    input  logic              clr_addr,
    output logic              gnt_layer,
    output logic              gnt_file,
    output logic              gnt_decomp,
    output logic              Write_Layer,
    output logic              Write_Files,
    output logic              File_Type,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       burst_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t            state_r, nextState_s;
    // Source vectors: bit 0 layer, bit 1 file, bit 2 decomp
    logic [2:0]        req_s, valid_s, last_s, avail_s, pick_s;
    logic [2:0]        gnt_r, nextGnt_s;
    logic [2:0]        mask_r, nextMask_s;
    logic [2:0]        relSrc_r, nextRelSrc_s;
    logic              forced_r, nextForced_s;
    logic [15:0]       burstCnt_r, nextBurst_s;
    logic              writeLayer_r, writeFiles_r, fileType_r;
    logic [ADDR_W-1:0] layerAddr_r, fileAddr_r, decompAddr_r;
    logic              reqG_s, validG_s, lastG_s, accept_s, hitMax_s;

    assign req_s   = {req_decomp, req_file, req_layer};
    assign valid_s = {valid_decomp, valid_file, valid_layer};
    assign last_s  = {last_decomp, last_file, last_layer};

    assign reqG_s   = |(req_s & gnt_r);
    assign validG_s = |(valid_s & gnt_r);
    assign lastG_s  = |(last_s & gnt_r);
    assign accept_s = (state_r == BUSY) && validG_s;
    // True when the word being accepted now is the BURST_MAX-th of the grant
    assign hitMax_s = (({1'b0, burstCnt_r} + 17'd1) == 17'(BURST_MAX));
    assign avail_s  = req_s & ~mask_r;

    // Fixed-priority pick over unmasked requests: layer > file > decomp
    always_comb begin
        pick_s = 3'b000;
        if (avail_s[0]) begin
            pick_s = 3'b001;
        end else if (avail_s[1]) begin
            pick_s = 3'b010;
        end else if (avail_s[2]) begin
            pick_s = 3'b100;
        end else begin
            pick_s = 3'b000;
        end
    end

    // Next-state, next-grant, mask and burst counter logic
    always_comb begin
        nextState_s  = state_r;
        nextGnt_s    = gnt_r;
        nextMask_s   = mask_r;
        nextRelSrc_s = relSrc_r;
        nextForced_s = forced_r;
        nextBurst_s  = burstCnt_r;
        case (state_r)
            IDLE: begin
                // The mask only ever influences a single arbitration
                nextMask_s = 3'b000;
                if (|avail_s) begin
                    nextState_s = BUSY;
                    nextGnt_s   = pick_s;
                    nextBurst_s = 16'd0;
                end else begin
                    nextGnt_s   = 3'b000;
                end
            end
            BUSY: begin
                if (accept_s) begin
                    nextBurst_s = burstCnt_r + 16'd1;
                end else begin
                    nextBurst_s = burstCnt_r;
                end
                // last wins over forced release, so last at BURST_MAX is unmasked
                if (accept_s && lastG_s) begin
                    nextState_s  = RELEASE;
                    nextGnt_s    = 3'b000;
                    nextRelSrc_s = gnt_r;
                    nextForced_s = 1'b0;
                end else if (accept_s && hitMax_s) begin
                    nextState_s  = RELEASE;
                    nextGnt_s    = 3'b000;
                    nextRelSrc_s = gnt_r;
                    nextForced_s = 1'b1;
                end else if (!reqG_s) begin
                    nextState_s  = RELEASE;
                    nextGnt_s    = 3'b000;
                    nextRelSrc_s = gnt_r;
                    nextForced_s = 1'b0;
                end else begin
                    nextState_s  = BUSY;
                end
            end
            RELEASE: begin
                nextState_s = IDLE;
                nextGnt_s   = 3'b000;
                // Mask the forced-out source only if someone else is waiting
                if (forced_r && (|(req_s & ~relSrc_r))) begin
                    nextMask_s = relSrc_r;
                end else begin
                    nextMask_s = 3'b000;
                end
            end
            default: begin
                nextState_s = IDLE;
                nextGnt_s   = 3'b000;
                nextMask_s  = 3'b000;
            end
        endcase
    end

    // Control state, grant and select registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            gnt_r        <= 3'b000;
            mask_r       <= 3'b000;
            relSrc_r     <= 3'b000;
            forced_r     <= 1'b0;
            burstCnt_r   <= 16'd0;
            writeLayer_r <= 1'b0;
            writeFiles_r <= 1'b0;
            fileType_r   <= 1'b0;
        end else begin
            state_r      <= nextState_s;
            gnt_r        <= nextGnt_s;
            mask_r       <= nextMask_s;
            relSrc_r     <= nextRelSrc_s;
            forced_r     <= nextForced_s;
            burstCnt_r   <= nextBurst_s;
            writeLayer_r <= nextGnt_s[0];
            writeFiles_r <= nextGnt_s[1] | nextGnt_s[2];
            fileType_r   <= nextGnt_s[1];
        end
    end

    // Per-source address counters; clr_addr takes precedence over increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            layerAddr_r  <= LAYER_BASE;
            fileAddr_r   <= FILE_BASE;
            decompAddr_r <= DECOMP_BASE;
        end else if (clr_addr) begin
            layerAddr_r  <= LAYER_BASE;
            fileAddr_r   <= FILE_BASE;
            decompAddr_r <= DECOMP_BASE;
        end else begin
            if (accept_s && gnt_r[0]) layerAddr_r  <= layerAddr_r + ADDR_W'(1);
            else                      layerAddr_r  <= layerAddr_r;
            if (accept_s && gnt_r[1]) fileAddr_r   <= fileAddr_r + ADDR_W'(1);
            else                      fileAddr_r   <= fileAddr_r;
            if (accept_s && gnt_r[2]) decompAddr_r <= decompAddr_r + ADDR_W'(1);
            else                      decompAddr_r <= decompAddr_r;
        end
    end

    // Address mux: granted source's counter, layer counter when nobody holds a grant
    always_comb begin
        if (gnt_r[1]) begin
            mem_addr = fileAddr_r;
        end else if (gnt_r[2]) begin
            mem_addr = decompAddr_r;
        end else begin
            mem_addr = layerAddr_r;
        end
    end

    assign mem_we      = accept_s;
    assign gnt_layer   = gnt_r[0];
    assign gnt_file    = gnt_r[1];
    assign gnt_decomp  = gnt_r[2];
    assign Write_Layer = writeLayer_r;
    assign Write_Files = writeFiles_r;
    assign File_Type   = fileType_r;
    assign burst_cnt   = burstCnt_r;

endmodule

// File: doc/io_write_arbiter.md
Name: io_write_arbiter

Overview:
- Arbitrates the shared IO write port between three requesters: layer loader, file writer and decompressor.
- Drives the write-source select lines (Write_Files, File_Type, Write_Layer) of the one-bit write-source mux array, plus the write enable and write address.
- Grants whole bursts. Each source keeps its own persistent address counter, so a pre-empted source resumes where it stopped.

Parameters:
ADDR_W, 16, width of mem_addr and of the address counters
BURST_MAX, 64, maximum words per grant before forced release (range 1..2^16-1)
LAYER_BASE, 16'h0000, start/clear address of the layer region
FILE_BASE, 16'h4000, start/clear address of the file region
DECOMP_BASE, 16'h8000, start/clear address of the decompressor region

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
req_layer / req_file / req_decomp  in  1 each  level request; held while the source has data
valid_layer / valid_file / valid_decomp  in  1 each  source presents a word this cycle
last_layer / last_file / last_decomp  in  1 each  qualifies valid_x; marks the final word of the burst
clr_addr  in  1  reload all three address counters to their base values
gnt_layer / gnt_file / gnt_decomp  out  1 each  one-hot grant, registered
Write_Layer, Write_Files, File_Type  out  1 each  mux selects, registered
mem_we  out  1  write strobe = (granted source's valid) AND state BUSY, combinational
mem_addr  out  ADDR_W  address counter of the granted source; value of the layer counter when idle
burst_cnt  out  16  words accepted in the current grant

Behaviour:
Reset (asynchronous, any time, including mid-burst):
- state IDLE; all grants, selects and mem_we = 0.
- burst_cnt = 0; counters = their base values; mask cleared.

States: IDLE, BUSY, RELEASE.

IDLE:
- Arbitrate over unmasked requests. Priority: layer > file > decomp.
- Winner registered: grant and selects rise on the next edge, state goes to BUSY, burst_cnt = 0.
- Select encoding:
  - layer: Write_Layer=1, Write_Files=0, File_Type=0
  - file: Write_Layer=0, Write_Files=1, File_Type=1
  - decomp: Write_Layer=0, Write_Files=1, File_Type=0
  - none: all 0
- With no unmasked request, stay in IDLE.

BUSY:
- Accepted word = granted valid_x = 1. On an accepted word:
  - mem_we = 1 in the same cycle, with mem_addr = current counter.
  - The counter increments at the edge, wrapping modulo 2^ADDR_W.
  - burst_cnt increments.
- Valid from non-granted sources is ignored.
- Exit to RELEASE on any of:
  - (a) accepted word with last_x = 1;
  - (b) accepted word that makes burst_cnt == BURST_MAX (forced release);
  - (c) granted req_x drops without last (abort; no write in that cycle unless valid_x = 1).

RELEASE (one cycle):
- Grants, selects and mem_we = 0.
- Mask rule: on a forced release (b), mask that source for the next arbitration only, and only if another source is requesting. The mask clears after that arbitration.
- Always return to IDLE.

Timing:
- Gap between two grants = 2 cycles (RELEASE, then IDLE arbitration).
- First write no earlier than 1 cycle after req.

Boundary cases:
- clr_addr: reloads all counters at the edge, in any state.
  - If it coincides with an accepted word, that word uses the old address; the counter becomes base (clr wins over increment).
- Simultaneous last_x and burst_cnt reaching BURST_MAX: treated as last, no mask.
- BURST_MAX = 1: every grant is exactly one word.
- A request asserted during BUSY or RELEASE by a higher-priority source does not pre-empt the current grant.

Test Plan:
- Reset, then req_file=1 with 3 valid words, last on the 3rd:
  - gnt_file rises 1 cycle after req; selects = Write_Files=1, File_Type=1, Write_Layer=0.
  - mem_we pulses at addresses 0x4000, 0x4001, 0x4002; then RELEASE, then IDLE.
- req_layer and req_decomp asserted in the same cycle:
  - Layer granted first (Write_Layer=1).
  - After layer's last word: 2 idle cycles, then gnt_decomp with Write_Files=1, File_Type=0, address 0x8000.
- BURST_MAX=4, req_decomp and req_file held continuously, decomp already granted:
  - Forced release after 4 words; file granted next; decomp granted after the file's last word.
  - Decomp resumes at 0x8004.
- Decomp counter preset near 0xFFFF with ADDR_W=16:
  - Writes at 0xFFFF then 0x0000 (wrap).
  - clr_addr during an accepted word: that word at the old address, next word at DECOMP_BASE.
- req_layer dropped mid-burst after 2 words, no last:
  - Abort to RELEASE with no write in the drop cycle.
  - Re-request resumes at LAYER_BASE+2.
- reset asserted mid-burst (asynchronous, between edges):
  - All grants, selects and mem_we drop immediately; state IDLE; counters at base values.
